// File: rtl/global_load_sequencer_if.sv
// global_load_sequencer_if: scheduler, instruction-fetch and global-register-write signals
//   step/step_ready/step_done/halted/pc      scheduler handshake and status
//   mem_read_req/addr/valid/data             instruction memory fetch
//   glob_reg_write_en/addr/data              global register file write port
//   slave modport is the sequencer side; master modport is the environment side.
interface global_load_sequencer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 24
);
    logic                   step;
    logic                   step_ready;
    logic                   step_done;
    logic                   halted;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   mem_read_req;
    logic [ADDR_WIDTH-1:0]  mem_read_addr;
    logic                   mem_read_valid;
    logic [INSTR_WIDTH-1:0] mem_read_data;
    logic                   glob_reg_write_en;
    logic [3:0]             glob_reg_write_addr;
    logic [DATA_WIDTH-1:0]  glob_reg_write_data;

    modport slave (
        input  step, mem_read_valid, mem_read_data,
        output step_ready, step_done, halted, pc, mem_read_req, mem_read_addr,
               glob_reg_write_en, glob_reg_write_addr, glob_reg_write_data
    );

    modport master (
        output step, mem_read_valid, mem_read_data,
        input  step_ready, step_done, halted, pc, mem_read_req, mem_read_addr,
               glob_reg_write_en, glob_reg_write_addr, glob_reg_write_data
    );
endinterface

// File: rtl/global_load_sequencer.sv
// global_load_sequencer: fetches one instruction per step, turns LDI into a global register write
//   clk    clock
//   reset  synchronous active-high reset
//   bus    slave side of global_load_sequencer_if (scheduler, fetch and write ports)
module global_load_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 24
) (
    input logic                   clk,
    input logic                   reset,
    global_load_sequencer_if.slave bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_EXEC, ST_HALTED} state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t                 state, state_next;
    logic [ADDR_WIDTH-1:0]  pc, pc_next;
    logic [INSTR_WIDTH-1:0] instr;
    logic [3:0]             opcode;

    assign opcode = instr[23:20];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            instr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == ST_WAIT && bus.mem_read_valid)
                instr <= bus.mem_read_data;
        end
    end

    // pc wraps naturally at 2^ADDR_WIDTH; HALT leaves it pointing at the HALT itself
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            ST_IDLE:   state_next = bus.step ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_next = ST_WAIT;
            ST_WAIT:   state_next = bus.mem_read_valid ? ST_EXEC : ST_WAIT;
            ST_EXEC: begin
                state_next = (opcode == OP_HALT) ? ST_HALTED : ST_IDLE;
                pc_next    = (opcode == OP_HALT) ? pc : pc + 1'b1;
            end
            default:   state_next = ST_HALTED;
        endcase
    end

    // every output comes from registered state/instr only
    assign bus.step_ready          = state == ST_IDLE;
    assign bus.mem_read_req        = state == ST_FETCH;
    assign bus.step_done           = state == ST_EXEC;
    assign bus.halted              = state == ST_HALTED;
    assign bus.pc                  = pc;
    assign bus.mem_read_addr       = pc;
    assign bus.glob_reg_write_en   = state == ST_EXEC && opcode == OP_LDI;
    assign bus.glob_reg_write_addr = instr[19:16];
    assign bus.glob_reg_write_data = instr[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_global_load_sequencer.sv
// tb_global_load_sequencer: directed table-driven bench for global_load_sequencer
module tb_global_load_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    global_load_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .INSTR_WIDTH(24)) bus ();

    global_load_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .INSTR_WIDTH(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] instr;
        int          lat;
        bit          step_in_wait;
        bit          we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic [7:0]  pc_before;
        logic [7:0]  pc_after;
        bit          halt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full step transaction; called at a negedge with the DUT in IDLE.
    task automatic do_step(input vec_t v);
        chk("step_ready", 32'(bus.step_ready), 1);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        chk("req_fetch", 32'(bus.mem_read_req), 1);
        chk("req_addr", 32'(bus.mem_read_addr), 32'(v.pc_before));
        chk("done_fetch", 32'(bus.step_done), 0);
        @(negedge clk);
        for (int k = 0; k <= v.lat; k++) begin
            chk("req_once", 32'(bus.mem_read_req), 0);
            chk("done_early", 32'(bus.step_done), 0);
            bus.step           = v.step_in_wait && k == 0;
            bus.mem_read_valid = k == v.lat;
            bus.mem_read_data  = k == v.lat ? v.instr : 24'h000000;
            @(negedge clk);
        end
        bus.step           = 1'b0;
        bus.mem_read_valid = 1'b0;
        bus.mem_read_data  = 24'h000000;
        chk("done_exec", 32'(bus.step_done), 1);
        chk("we_exec", 32'(bus.glob_reg_write_en), 32'(v.we));
        if (v.we) begin
            chk("waddr", 32'(bus.glob_reg_write_addr), 32'(v.waddr));
            chk("wdata", 32'(bus.glob_reg_write_data), 32'(v.wdata));
        end
        @(negedge clk);
        chk("done_pulse", 32'(bus.step_done), 0);
        chk("we_pulse", 32'(bus.glob_reg_write_en), 0);
        chk("pc_after", 32'(bus.pc), 32'(v.pc_after));
        chk("halted", 32'(bus.halted), 32'(v.halt));
        chk("ready_after", 32'(bus.step_ready), 32'(!v.halt));
        chk("req_after", 32'(bus.mem_read_req), 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_t nop;
        vecs[0] = '{24'h13ABCD, 0, 0, 1, 4'h3, 16'hABCD, 8'd0, 8'd1, 0};
        vecs[1] = '{24'h151234, 4, 1, 1, 4'h5, 16'h1234, 8'd1, 8'd2, 0};
        vecs[2] = '{24'h275555, 1, 0, 0, 4'h0, 16'h0000, 8'd2, 8'd3, 0};
        vecs[3] = '{24'h000000, 0, 0, 0, 4'h0, 16'h0000, 8'd3, 8'd4, 0};
        vecs[4] = '{24'h1FFFFF, 2, 1, 1, 4'hF, 16'hFFFF, 8'd4, 8'd5, 0};
        vecs[5] = '{24'hF00000, 0, 0, 0, 4'h0, 16'h0000, 8'd5, 8'd5, 1};

        bus.step           = 1'b0;
        bus.mem_read_valid = 1'b0;
        bus.mem_read_data  = 24'h000000;
        reset              = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.step_ready), 1);
        chk("rst_req", 32'(bus.mem_read_req), 0);
        chk("rst_done", 32'(bus.step_done), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_pc", 32'(bus.pc), 0);
        chk("rst_addr", 32'(bus.mem_read_addr), 0);
        chk("rst_we", 32'(bus.glob_reg_write_en), 0);
        chk("rst_waddr", 32'(bus.glob_reg_write_addr), 0);
        chk("rst_wdata", 32'(bus.glob_reg_write_data), 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) do_step(vecs[i]);

        // HALTED ignores step and never fetches
        for (int i = 0; i < 4; i++) begin
            bus.step = 1'b1;
            @(negedge clk);
            chk("halt_req", 32'(bus.mem_read_req), 0);
            chk("halt_halted", 32'(bus.halted), 1);
            chk("halt_ready", 32'(bus.step_ready), 0);
            chk("halt_pc", 32'(bus.pc), 5);
        end
        bus.step = 1'b0;
        apply_reset();
        chk("unhalt_halted", 32'(bus.halted), 0);
        chk("unhalt_pc", 32'(bus.pc), 0);
        chk("unhalt_ready", 32'(bus.step_ready), 1);

        // NOP stream up to pc=FF, then one more wraps to 00
        for (int i = 0; i < 256; i++) begin
            nop = '{24'h200000, 0, 0, 0, 4'h0, 16'h0000, 8'(i), 8'(i + 1), 0};
            do_step(nop);
        end
        chk("wrap_pc", 32'(bus.pc), 0);

        // spurious valid in FETCH, then reset in WAIT with a stale valid afterwards
        bus.step = 1'b1;
        @(negedge clk);
        bus.step           = 1'b0;
        bus.mem_read_valid = 1'b1;
        bus.mem_read_data  = 24'h13ABCD;
        chk("spur_req", 32'(bus.mem_read_req), 1);
        @(negedge clk);
        bus.mem_read_valid = 1'b0;
        chk("spur_done", 32'(bus.step_done), 0);
        chk("spur_we", 32'(bus.glob_reg_write_en), 0);
        @(negedge clk);
        chk("wait_hold_done", 32'(bus.step_done), 0);
        chk("wait_hold_ready", 32'(bus.step_ready), 0);
        reset = 1'b1;
        @(negedge clk);
        reset              = 1'b0;
        bus.mem_read_valid = 1'b1;
        @(negedge clk);
        bus.mem_read_valid = 1'b0;
        bus.mem_read_data  = 24'h000000;
        chk("stale_we", 32'(bus.glob_reg_write_en), 0);
        chk("stale_done", 32'(bus.step_done), 0);
        chk("stale_ready", 32'(bus.step_ready), 1);
        @(negedge clk);
        chk("stale_we2", 32'(bus.glob_reg_write_en), 0);
        chk("stale_done2", 32'(bus.step_done), 0);
        chk("stale_ready2", 32'(bus.step_ready), 1);
        chk("stale_pc", 32'(bus.pc), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
